// File: rtl/lfsr_pkg.sv
// Shared types, feedback helper and maximal-length tap masks for the PRBS
// generator/checker slice.
package lfsr_pkg;

    typedef enum logic {
        HUNT,
        LOCK
    } chk_state_t;

    localparam logic [1:0]  LFSR_TAPS_2  = 2'h3;
    localparam logic [2:0]  LFSR_TAPS_3  = 3'h5;
    localparam logic [3:0]  LFSR_TAPS_4  = 4'h9;
    localparam logic [7:0]  LFSR_TAPS_8  = 8'h1D;
    localparam logic [15:0] LFSR_TAPS_16 = 16'h002D;

    // Callers zero-extend to 32 bits so one function serves every width.
    function automatic logic lfsr_fb(input logic [31:0] state, input logic [31:0] taps);
        return ^(state & taps);
    endfunction

endpackage

// File: rtl/lfsr_prbs_if.sv
// Generator and checker signal bundle; master drives stimulus, slave is the
// PRBS block.
interface lfsr_prbs_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned ERRW  = 16
);
    logic             load;
    logic [WIDTH-1:0] seed;
    logic             gen_en;
    logic [WIDTH-1:0] gen_state;
    logic             gen_bit;
    logic             chk_valid;
    logic             chk_bit;
    logic             err_clr;
    logic             chk_lock;
    logic             chk_err;
    logic [ERRW-1:0]  err_cnt;

    modport master (
        output load, seed, gen_en, chk_valid, chk_bit, err_clr,
        input  gen_state, gen_bit, chk_lock, chk_err, err_cnt
    );

    modport slave (
        input  load, seed, gen_en, chk_valid, chk_bit, err_clr,
        output gen_state, gen_bit, chk_lock, chk_err, err_cnt
    );

endinterface

// File: rtl/lfsr_core.sv
// Fibonacci LFSR register: seed load with zero-seed protection, step enable.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS_16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             en,
    output logic [WIDTH-1:0] state
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= '1;
        end else if (load) begin
            state <= (seed == '0) ? '1 : seed;
        end else if (en) begin
            state <= {lfsr_fb(32'(state), 32'(TAPS)), state[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/lfsr_prbs.sv
// PRBS generator plus self-synchronising checker: HUNT fills and verifies the
// reference register, LOCK free-runs on its own prediction and counts errors.
module lfsr_prbs
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH    = 16,
    parameter logic [WIDTH-1:0] TAPS     = LFSR_TAPS_16,
    parameter int unsigned      SYNC_CNT = 8,
    parameter int unsigned      LOSS_CNT = 4,
    parameter int unsigned      ERRW     = 16
) (
    input logic        clk,
    input logic        rst,
    lfsr_prbs_if.slave bus
);

    localparam int unsigned     FW       = $clog2(WIDTH + 1);
    localparam logic [FW-1:0]   FILL_MAX = FW'(WIDTH);

    chk_state_t       state_q, state_d;
    logic [WIDTH-1:0] chk_reg, chk_reg_d;
    logic [FW-1:0]    fill, fill_d;
    logic [7:0]       match, match_d;
    logic [7:0]       miss, miss_d;
    logic [ERRW-1:0]  err_cnt_q, err_cnt_d;
    logic             chk_err_q;
    logic             exp_bit;
    logic             mismatch;
    logic             err_hit;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_gen (
        .clk   (clk),
        .rst   (rst),
        .load  (bus.load),
        .seed  (bus.seed),
        .en    (bus.gen_en),
        .state (bus.gen_state)
    );

    assign bus.gen_bit  = bus.gen_state[0];
    assign bus.chk_lock = (state_q == LOCK);
    assign bus.chk_err  = chk_err_q;
    assign bus.err_cnt  = err_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= HUNT;
            chk_reg   <= '0;
            fill      <= '0;
            match     <= '0;
            miss      <= '0;
            err_cnt_q <= '0;
            chk_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            chk_reg   <= chk_reg_d;
            fill      <= fill_d;
            match     <= match_d;
            miss      <= miss_d;
            err_cnt_q <= err_cnt_d;
            chk_err_q <= err_hit;
        end
    end

    always_comb begin
        exp_bit   = lfsr_fb(32'(chk_reg), 32'(TAPS));
        mismatch  = (bus.chk_bit != exp_bit);
        state_d   = state_q;
        chk_reg_d = chk_reg;
        fill_d    = fill;
        match_d   = match;
        miss_d    = miss;
        err_hit   = 1'b0;

        if (bus.chk_valid) begin
            case (state_q)
                HUNT: begin
                    chk_reg_d = {bus.chk_bit, chk_reg[WIDTH-1:1]};
                    if (fill != FILL_MAX) begin
                        fill_d = fill + FW'(1);
                    end else if (mismatch) begin
                        match_d = '0;
                    end else if (match + 8'd1 == 8'(SYNC_CNT)) begin
                        match_d = '0;
                        state_d = LOCK;
                    end else begin
                        match_d = match + 8'd1;
                    end
                end
                LOCK: begin
                    // Reference advances on its own prediction, never on the received bit.
                    chk_reg_d = {exp_bit, chk_reg[WIDTH-1:1]};
                    if (mismatch) begin
                        err_hit = 1'b1;
                        if (miss + 8'd1 == 8'(LOSS_CNT)) begin
                            state_d = HUNT;
                            fill_d  = '0;
                            match_d = '0;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss + 8'd1;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        if (bus.err_clr) begin
            err_cnt_d = err_hit ? ERRW'(1) : '0;
        end else if (err_hit && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERRW'(1);
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

endmodule

// File: tb/tb_lfsr_prbs.sv
// Scoreboard bench for lfsr_prbs (WIDTH=4, TAPS=9, SYNC=4, LOSS=3); a second
// instance with ERRW=2 shares the stimulus to exercise counter saturation.
module tb_lfsr_prbs;

    typedef struct {
        int    due;
        string name;
        int    sel;
        int    val;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q[$];
    exp_t rq[$];
    logic [3:0] seq [15];

    always #5 clk = ~clk;

    lfsr_prbs_if #(.WIDTH(4), .ERRW(16)) bi ();
    lfsr_prbs_if #(.WIDTH(4), .ERRW(2))  bs ();

    assign bs.load      = bi.load;
    assign bs.seed      = bi.seed;
    assign bs.gen_en    = bi.gen_en;
    assign bs.chk_valid = bi.chk_valid;
    assign bs.chk_bit   = bi.chk_bit;
    assign bs.err_clr   = bi.err_clr;

    lfsr_prbs #(.WIDTH(4), .TAPS(4'h9), .SYNC_CNT(4), .LOSS_CNT(3), .ERRW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bi)
    );

    lfsr_prbs #(.WIDTH(4), .TAPS(4'h9), .SYNC_CNT(4), .LOSS_CNT(3), .ERRW(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bs)
    );

    function automatic logic [31:0] actual(int sel);
        case (sel)
            0:       return 32'(bi.gen_state);
            1:       return 32'(bi.gen_bit);
            2:       return 32'(bi.chk_lock);
            3:       return 32'(bi.chk_err);
            4:       return 32'(bi.err_cnt);
            default: return 32'(bs.err_cnt);
        endcase
    endfunction

    task automatic check(input exp_t e);
        logic [31:0] a;
        a = actual(e.sel);
        n_tests++;
        if (a !== 32'(e.val)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", e.name, a, e.val, cyc);
        end
    endtask

    // Clocked monitor: compares everything due after this rising edge.
    initial forever begin
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            if (e.due < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s: stale entry due %0d, now %0d", e.name, e.due, cyc);
            end else begin
                check(e);
            end
        end
    end

    // Asynchronous-reset monitor: outputs must change without a clock edge.
    initial forever begin
        @(negedge rst);
        #1;
        while (rq.size() > 0) check(rq.pop_front());
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic expect_at(input string name, input int sel, input int val);
        q.push_back('{due: cyc + 1, name: name, sel: sel, val: val});
    endtask

    task automatic exp_chk(input string name, input int lock, input int err, input int ec, input int ec2);
        expect_at({name, ".lock"}, 2, lock);
        expect_at({name, ".err"}, 3, err);
        expect_at({name, ".err_cnt"}, 4, ec);
        expect_at({name, ".err_cnt_sat"}, 5, ec2);
    endtask

    task automatic exp_reset(input string name);
        expect_at({name, ".gen_state"}, 0, 15);
        expect_at({name, ".gen_bit"}, 1, 1);
        exp_chk(name, 0, 0, 0, 0);
    endtask

    task automatic tick(input logic ld, input logic [3:0] sd, input logic en,
                        input logic v, input logic inv, input logic clr);
        @(negedge clk);
        bi.load      = ld;
        bi.seed      = sd;
        bi.gen_en    = en;
        bi.chk_valid = v;
        bi.chk_bit   = bi.gen_bit ^ inv;
        bi.err_clr   = clr;
    endtask

    initial begin
        seq = '{4'hF, 4'h7, 4'hB, 4'h5, 4'hA, 4'hD, 4'h6, 4'h3,
                4'h9, 4'h4, 4'h2, 4'h1, 4'h8, 4'hC, 4'hE};
        rst          = 1'b0;
        bi.load      = 1'b0;
        bi.seed      = '0;
        bi.gen_en    = 1'b0;
        bi.chk_valid = 1'b0;
        bi.chk_bit   = 1'b0;
        bi.err_clr   = 1'b0;

        // Reset dominates busy inputs.
        repeat (2) begin
            tick(1'b1, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0);
            exp_reset("reset");
        end
        tick(0, 0, 0, 0, 0, 0);
        exp_reset("reset_idle");
        rst = 1'b1;

        // Free-run: full maximal-length period returns to F after 15 steps.
        for (int i = 0; i < 15; i++) begin
            tick(0, 0, 1, 0, 0, 0);
            expect_at("freerun", 0, int'(seq[(i + 1) % 15]));
            if (i < 4) expect_at("freerun_bit", 1, int'(seq[i + 1] & 4'h1));
        end
        tick(0, 0, 0, 0, 0, 0);
        expect_at("hold", 0, 15);

        // Load priority and zero-seed protection.
        tick(0, 0, 1, 0, 0, 0);
        expect_at("step", 0, 7);
        tick(1, 4'h0, 0, 0, 0, 0);
        expect_at("load_zero", 0, 15);
        tick(1, 4'h5, 1, 0, 0, 0);
        expect_at("load_over_en", 0, 5);
        tick(0, 0, 0, 0, 0, 0);
        expect_at("hold_after_load", 0, 5);

        // Loopback: lock after WIDTH+SYNC_CNT = 8 valid bits, no errors.
        for (int i = 1; i <= 100; i++) begin
            tick(0, 0, 1, 1, 0, 0);
            expect_at("lock_rise", 2, (i >= 8) ? 1 : 0);
            expect_at("clean_err", 3, 0);
            if (i % 20 == 0) expect_at("clean_cnt", 4, 0);
        end

        // Single error keeps lock.
        tick(0, 0, 1, 1, 1, 0);
        exp_chk("single_err", 1, 1, 1, 1);
        repeat (5) begin
            tick(0, 0, 1, 1, 0, 0);
            exp_chk("single_after", 1, 0, 1, 1);
        end

        // Three consecutive errors drop lock; the third is still counted.
        tick(0, 0, 1, 1, 1, 0);
        exp_chk("burst1", 1, 1, 2, 2);
        tick(0, 0, 1, 1, 1, 0);
        exp_chk("burst2", 1, 1, 3, 3);
        tick(0, 0, 1, 1, 1, 0);
        exp_chk("burst3", 0, 1, 4, 3);
        for (int i = 1; i <= 10; i++) begin
            tick(0, 0, 1, 1, 0, 0);
            exp_chk("relock", (i >= 8) ? 1 : 0, 0, 4, 3);
        end

        // Clear, then isolated errors saturate the 2-bit counter at 3.
        tick(0, 0, 1, 1, 0, 1);
        exp_chk("clr_alone", 1, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            tick(0, 0, 1, 1, 1, 0);
            exp_chk("iso_err", 1, 1, k, (k > 3) ? 3 : k);
            repeat (2) begin
                tick(0, 0, 1, 1, 0, 0);
                exp_chk("iso_clean", 1, 0, k, (k > 3) ? 3 : k);
            end
        end
        tick(0, 0, 1, 1, 1, 1);
        exp_chk("clr_with_err", 1, 1, 1, 1);
        tick(0, 0, 1, 1, 0, 0);
        exp_chk("clr_with_err_after", 1, 0, 1, 1);
        tick(0, 0, 0, 0, 0, 1);
        exp_chk("clr_no_valid", 1, 0, 0, 0);

        // Asynchronous reset while chk_err is pulsing.
        tick(0, 0, 1, 1, 1, 0);
        exp_chk("pre_reset_err", 1, 1, 1, 1);
        @(negedge clk);
        rq.push_back('{due: 0, name: "async.gen_state", sel: 0, val: 15});
        rq.push_back('{due: 0, name: "async.lock", sel: 2, val: 0});
        rq.push_back('{due: 0, name: "async.err", sel: 3, val: 0});
        rq.push_back('{due: 0, name: "async.err_cnt", sel: 4, val: 0});
        rq.push_back('{due: 0, name: "async.err_cnt_sat", sel: 5, val: 0});
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 1, logic'(i % 2), 0, 0);
            exp_reset("in_reset");
        end
        tick(0, 0, 0, 0, 0, 0);
        exp_reset("reset_release");
        rst = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick(0, 0, 1, 1, 0, 0);
            exp_chk("relock_after_rst", (i >= 8) ? 1 : 0, 0, 0, 0);
        end

        tick(0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        n_tests++;
        if (q.size() + rq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size() + rq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
